// File: rtl/wt_store_wbuf_pkg.sv
// Shared write-buffer types: entry state, entry record, sizing constants.
// Used by wt_store_wbuf and wt_wbuf_tid_alloc.
package wt_store_wbuf_pkg;

    localparam int unsigned WBUF_DEPTH   = 8;
    localparam int unsigned MEM_TID_W    = 2;
    localparam int unsigned WBUF_TID_MAX = 8;

    typedef enum logic [1:0] {
        WBUF_FREE     = 2'd0,
        WBUF_VALID    = 2'd1,
        WBUF_INFLIGHT = 2'd2
    } wbuf_state_e;

    // tid is sized for the widest supported TID_W and zero-extended
    typedef struct packed {
        wbuf_state_e             state;
        logic [WBUF_TID_MAX-1:0] tid;
    } wbuf_entry_t;

endpackage

// File: rtl/wt_wbuf_tid_alloc.sv
// Free-TID bitmap with a lowest-free priority encoder.
// A released TID only becomes visible as free after the clock edge.
module wt_wbuf_tid_alloc
    import wt_store_wbuf_pkg::*;
#(
    parameter int unsigned TID_W = MEM_TID_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             alloc_i,
    input  logic             release_i,
    input  logic [TID_W-1:0] release_tid_i,
    output logic             free_o,
    output logic [TID_W-1:0] tid_o
);

    localparam int unsigned NTID = 1 << TID_W;

    logic [NTID-1:0] busy_q;

    always_comb begin
        free_o = 1'b0;
        tid_o  = '0;
        for (int i = int'(NTID) - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_o = 1'b1;
                tid_o  = TID_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            if (release_i) begin
                busy_q[release_tid_i] <= 1'b0;
            end
            if (alloc_i && free_o) begin
                busy_q[tid_o] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/wt_store_wbuf.sv
// Write-through store buffer: ring of entries, in-order issue, any-order ack.
// Define WT_STORE_WBUF_COALESCE_EN to merge stores into the newest VALID entry.
module wt_store_wbuf
    import wt_store_wbuf_pkg::*;
#(
    parameter int unsigned DEPTH  = WBUF_DEPTH,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TID_W  = MEM_TID_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                st_valid_i,
    output logic                st_ready_o,
    input  logic [ADDR_W-1:0]   st_addr_i,
    input  logic [DATA_W-1:0]   st_data_i,
    input  logic [DATA_W/8-1:0] st_be_i,
    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_data_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [TID_W-1:0]    mem_tid_o,
    input  logic                mem_ack_i,
    input  logic [TID_W-1:0]    mem_ack_tid_i,
    input  logic [ADDR_W-1:0]   chk_addr_i,
    output logic                chk_hit_o,
    output logic                empty_o
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] AL_MASK = ~ADDR_W'(BE_W - 1);

    wbuf_entry_t       ent_q  [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [BE_W-1:0]   be_q   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  iss_ptr_q;
    logic [PTR_W-1:0]  prev_ptr;
    logic [ADDR_W-1:0] st_addr_al;
    logic [ADDR_W-1:0] chk_addr_al;

    logic              tid_free;
    logic [TID_W-1:0]  tid_next;
    logic              wr_free;
    logic              merge;
    logic              alloc;
    logic              mrg_fire;
    logic              iss_fire;
    logic              ack_hit;
    logic [PTR_W-1:0]  ack_idx;

    assign st_addr_al  = st_addr_i & AL_MASK;
    assign chk_addr_al = chk_addr_i & AL_MASK;
    assign prev_ptr    = wr_ptr_q - PTR_W'(1);
    assign wr_free     = ent_q[wr_ptr_q].state == WBUF_FREE;

    assign mem_valid_o = (ent_q[iss_ptr_q].state == WBUF_VALID) && tid_free;
    assign mem_addr_o  = addr_q[iss_ptr_q];
    assign mem_data_o  = data_q[iss_ptr_q];
    assign mem_be_o    = be_q[iss_ptr_q];
    assign mem_tid_o   = tid_next;
    assign iss_fire    = mem_valid_o && mem_ready_i;

`ifdef WT_STORE_WBUF_COALESCE_EN
    // never touch the entry currently presented, so mem_* stay stable
    assign merge = (ent_q[prev_ptr].state == WBUF_VALID)
                && (addr_q[prev_ptr] == st_addr_al)
                && !((prev_ptr == iss_ptr_q) && mem_valid_o);
`else
    assign merge = 1'b0;
`endif

    assign st_ready_o = wr_free || merge;
    assign alloc      = st_valid_i && wr_free && !merge;
    assign mrg_fire   = st_valid_i && merge;

    always_comb begin
        ack_hit = 1'b0;
        ack_idx = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (mem_ack_i
                && (ent_q[i].state == WBUF_INFLIGHT)
                && (ent_q[i].tid == WBUF_TID_MAX'(mem_ack_tid_i))) begin
                ack_hit = 1'b1;
                ack_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        empty_o   = 1'b1;
        chk_hit_o = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ent_q[i].state != WBUF_FREE) begin
                empty_o = 1'b0;
                if (addr_q[i] == chk_addr_al) begin
                    chk_hit_o = 1'b1;
                end
            end
        end
    end

    wt_wbuf_tid_alloc #(
        .TID_W (TID_W)
    ) i_tid_alloc (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .alloc_i       (iss_fire),
        .release_i     (ack_hit),
        .release_tid_i (mem_ack_tid_i),
        .free_o        (tid_free),
        .tid_o         (tid_next)
    );

    // alloc, merge, issue and ack always address distinct entries
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            iss_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i]  <= '{state: WBUF_FREE, tid: '0};
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            if (alloc) begin
                ent_q[wr_ptr_q].state <= WBUF_VALID;
                addr_q[wr_ptr_q]      <= st_addr_al;
                data_q[wr_ptr_q]      <= st_data_i;
                be_q[wr_ptr_q]        <= st_be_i;
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (mrg_fire) begin
                for (int b = 0; b < int'(BE_W); b++) begin
                    if (st_be_i[b]) begin
                        data_q[prev_ptr][8*b +: 8] <= st_data_i[8*b +: 8];
                    end
                end
                be_q[prev_ptr] <= be_q[prev_ptr] | st_be_i;
            end
            if (iss_fire) begin
                ent_q[iss_ptr_q] <= '{state: WBUF_INFLIGHT,
                                      tid:   WBUF_TID_MAX'(tid_next)};
                iss_ptr_q        <= iss_ptr_q + PTR_W'(1);
            end
            if (ack_hit) begin
                ent_q[ack_idx].state <= WBUF_FREE;
            end
        end
    end

endmodule

// File: tb/tb_wt_store_wbuf.sv
// Self-checking bench for wt_store_wbuf: vector table, corner sequences,
// and a randomized run against a slot/TID reference model.
module tb_wt_store_wbuf;

    localparam int DEPTH = 8;
    localparam int NTID  = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        st_valid_i;
    logic        st_ready_o;
    logic [63:0] st_addr_i;
    logic [63:0] st_data_i;
    logic [7:0]  st_be_i;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_data_o;
    logic [7:0]  mem_be_o;
    logic [1:0]  mem_tid_o;
    logic        mem_ack_i;
    logic [1:0]  mem_ack_tid_i;
    logic [63:0] chk_addr_i;
    logic        chk_hit_o;
    logic        empty_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wt_store_wbuf #(
        .DEPTH  (8),
        .ADDR_W (64),
        .DATA_W (64),
        .TID_W  (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .st_valid_i    (st_valid_i),
        .st_ready_o    (st_ready_o),
        .st_addr_i     (st_addr_i),
        .st_data_i     (st_data_i),
        .st_be_i       (st_be_i),
        .mem_valid_o   (mem_valid_o),
        .mem_ready_i   (mem_ready_i),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_be_o      (mem_be_o),
        .mem_tid_o     (mem_tid_o),
        .mem_ack_i     (mem_ack_i),
        .mem_ack_tid_i (mem_ack_tid_i),
        .chk_addr_i    (chk_addr_i),
        .chk_hit_o     (chk_hit_o),
        .empty_o       (empty_o)
    );

    typedef struct {
        bit          sv;
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  b;
        bit          r;
        bit          ak;
        logic [1:0]  at;
        logic [63:0] c;
        bit          e_sr;
        bit          e_mv;
        logic [1:0]  e_tid;
        logic [63:0] e_addr;
        logic [63:0] e_data;
        logic [7:0]  e_be;
        bit          e_empty;
        bit          e_hit;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(bit sv, logic [63:0] a, logic [63:0] d,
                         logic [7:0] b, bit r, bit ak, logic [1:0] at,
                         logic [63:0] c);
        st_valid_i    = sv;
        st_addr_i     = a;
        st_data_i     = d;
        st_be_i       = b;
        mem_ready_i   = r;
        mem_ack_i     = ak;
        mem_ack_tid_i = at;
        chk_addr_i    = c;
    endtask

    task automatic idle(logic [63:0] c);
        drive(0, 64'h0, 64'h0, 8'h0, 0, 0, 2'd0, c);
    endtask

    task automatic do_reset();
        idle(64'h0);
        rst_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    function automatic vec_t mk(bit sv, logic [63:0] a, logic [63:0] d,
                                logic [7:0] b, bit r, bit ak, logic [1:0] at,
                                logic [63:0] c, bit esr, bit emv,
                                logic [1:0] et, logic [63:0] ea,
                                logic [63:0] ed, logic [7:0] eb,
                                bit eem, bit eh);
        vec_t v;
        v.sv = sv; v.a = a; v.d = d; v.b = b; v.r = r; v.ak = ak;
        v.at = at; v.c = c; v.e_sr = esr; v.e_mv = emv; v.e_tid = et;
        v.e_addr = ea; v.e_data = ed; v.e_be = eb;
        v.e_empty = eem; v.e_hit = eh;
        return v;
    endfunction

    // reference model: ring slots (0 free, 1 valid, 2 inflight) and TID set
    int          m_st   [DEPTH];
    logic [63:0] m_addr [DEPTH];
    logic [63:0] m_data [DEPTH];
    logic [7:0]  m_be   [DEPTH];
    int          m_tid  [DEPTH];
    bit          m_busy [NTID];
    int          m_wr;
    int          m_iss;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_st[i] = 0; m_addr[i] = 0; m_data[i] = 0;
            m_be[i] = 0; m_tid[i] = 0;
        end
        for (int t = 0; t < NTID; t++) m_busy[t] = 0;
        m_wr  = 0;
        m_iss = 0;
    endtask

    task automatic rand_cycle();
        logic [63:0] a, c, al, cal;
        int ftid, prev, ack_slot;
        bit e_mv, e_sr, e_hit, e_empty, mrg, wr_free;
        a = 64'h2000 + 64'($urandom_range(0, 7) * 8) + 64'($urandom_range(0, 7));
        c = 64'h2000 + 64'($urandom_range(0, 8) * 8) + 64'($urandom_range(0, 7));
        drive($urandom_range(0, 1) == 1, a, {$urandom, $urandom},
              8'($urandom), $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), c);
        #1;
        al  = a & ~64'h7;
        cal = c & ~64'h7;
        ftid = -1;
        for (int t = NTID - 1; t >= 0; t--) if (!m_busy[t]) ftid = t;
        e_mv = (m_st[m_iss] == 1) && (ftid >= 0);
        prev = (m_wr + DEPTH - 1) % DEPTH;
        mrg = 0;
`ifdef WT_STORE_WBUF_COALESCE_EN
        mrg = (m_st[prev] == 1) && (m_addr[prev] == al)
           && !((prev == m_iss) && e_mv);
`endif
        wr_free = (m_st[m_wr] == 0);
        e_sr = wr_free || mrg;
        e_hit = 0;
        e_empty = 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_st[i] != 0) begin
                e_empty = 0;
                if (m_addr[i] == cal) e_hit = 1;
            end
        end
        chk("rnd_st_ready", st_ready_o, e_sr);
        chk("rnd_mem_valid", mem_valid_o, e_mv);
        chk("rnd_chk_hit", chk_hit_o, e_hit);
        chk("rnd_empty", empty_o, e_empty);
        if (e_mv) begin
            chk("rnd_mem_addr", mem_addr_o, m_addr[m_iss]);
            chk("rnd_mem_data", mem_data_o, m_data[m_iss]);
            chk("rnd_mem_be", mem_be_o, m_be[m_iss]);
            chk("rnd_mem_tid", mem_tid_o, 64'(ftid));
        end
        ack_slot = -1;
        if (mem_ack_i) begin
            for (int i = 0; i < DEPTH; i++)
                if (m_st[i] == 2 && m_tid[i] == int'(mem_ack_tid_i)) ack_slot = i;
        end
        if (st_valid_i && mrg) begin
            for (int k = 0; k < 8; k++)
                if (st_be_i[k]) m_data[prev][8*k +: 8] = st_data_i[8*k +: 8];
            m_be[prev] = m_be[prev] | st_be_i;
        end else if (st_valid_i && wr_free) begin
            m_st[m_wr] = 1; m_addr[m_wr] = al;
            m_data[m_wr] = st_data_i; m_be[m_wr] = st_be_i;
            m_wr = (m_wr + 1) % DEPTH;
        end
        if (e_mv && mem_ready_i) begin
            m_st[m_iss] = 2; m_tid[m_iss] = ftid; m_busy[ftid] = 1;
            m_iss = (m_iss + 1) % DEPTH;
        end
        if (ack_slot >= 0) begin
            m_st[ack_slot] = 0;
            m_busy[mem_ack_tid_i] = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        // rows: push/issue/ack of one store, then tid exhaustion and reuse
        tbl[0]  = mk(1, 64'h1000, 64'hAA, 8'h01, 1, 0, 0, 64'h1000,
                     1, 0, 0, 0, 0, 0, 1, 0);
        tbl[1]  = mk(0, 0, 0, 0, 1, 0, 0, 64'h1000,
                     1, 1, 0, 64'h1000, 64'hAA, 8'h01, 0, 1);
        tbl[2]  = mk(0, 0, 0, 0, 0, 1, 0, 64'h1000,
                     1, 0, 0, 0, 0, 0, 0, 1);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 64'h1000,
                     1, 0, 0, 0, 0, 0, 1, 0);
        tbl[4]  = mk(1, 64'h100, 64'h11, 8'hFF, 1, 0, 0, 64'h120,
                     1, 0, 0, 0, 0, 0, 1, 0);
        tbl[5]  = mk(1, 64'h108, 64'h22, 8'hFF, 1, 0, 0, 64'h120,
                     1, 1, 0, 64'h100, 64'h11, 8'hFF, 0, 0);
        tbl[6]  = mk(1, 64'h110, 64'h33, 8'hFF, 1, 0, 0, 64'h120,
                     1, 1, 1, 64'h108, 64'h22, 8'hFF, 0, 0);
        tbl[7]  = mk(1, 64'h118, 64'h44, 8'hFF, 1, 0, 0, 64'h120,
                     1, 1, 2, 64'h110, 64'h33, 8'hFF, 0, 0);
        tbl[8]  = mk(1, 64'h120, 64'h55, 8'hFF, 1, 0, 0, 64'h120,
                     1, 1, 3, 64'h118, 64'h44, 8'hFF, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 1, 0, 0, 64'h120,
                     1, 0, 0, 0, 0, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 0, 1, 1, 2, 64'h110,
                     1, 0, 0, 0, 0, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 0, 1, 0, 0, 64'h110,
                     1, 1, 2, 64'h120, 64'h55, 8'hFF, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 1, 0, 64'h100,
                     1, 0, 0, 0, 0, 0, 0, 1);
        tbl[13] = mk(0, 0, 0, 0, 0, 1, 1, 64'h100,
                     1, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 3, 64'h120,
                     1, 0, 0, 0, 0, 0, 0, 1);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 2, 64'h120,
                     1, 0, 0, 0, 0, 0, 0, 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 64'h120,
                     1, 0, 0, 0, 0, 0, 1, 0);

        do_reset();
        idle(64'h1000);
        #1;
        chk("rst_st_ready", st_ready_o, 1);
        chk("rst_mem_valid", mem_valid_o, 0);
        chk("rst_chk_hit", chk_hit_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_data", mem_data_o, 0);
        chk("rst_mem_be", mem_be_o, 0);
        chk("rst_mem_tid", mem_tid_o, 0);
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].sv, tbl[i].a, tbl[i].d, tbl[i].b, tbl[i].r,
                  tbl[i].ak, tbl[i].at, tbl[i].c);
            #1;
            chk($sformatf("vec%0d_st_ready", i), st_ready_o, tbl[i].e_sr);
            chk($sformatf("vec%0d_mem_valid", i), mem_valid_o, tbl[i].e_mv);
            chk($sformatf("vec%0d_empty", i), empty_o, tbl[i].e_empty);
            chk($sformatf("vec%0d_chk_hit", i), chk_hit_o, tbl[i].e_hit);
            if (tbl[i].e_mv) begin
                chk($sformatf("vec%0d_tid", i), mem_tid_o, tbl[i].e_tid);
                chk($sformatf("vec%0d_addr", i), mem_addr_o, tbl[i].e_addr);
                chk($sformatf("vec%0d_data", i), mem_data_o, tbl[i].e_data);
                chk($sformatf("vec%0d_be", i), mem_be_o, tbl[i].e_be);
            end
            @(negedge clk);
        end

        // full buffer: 8 stores with memory stalled, 9th waits for an ack
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 64'h3000 + 64'(i * 8), 64'(i), 8'hFF, 0, 0, 0, 64'h0);
            #1;
            chk("fill_ready", st_ready_o, 1);
            @(negedge clk);
        end
        drive(1, 64'h4000, 64'h99, 8'hFF, 0, 0, 0, 64'h4000);
        #1;
        chk("full_ready", st_ready_o, 0);
        chk("full_stable_addr", mem_addr_o, 64'h3000);
        @(negedge clk);
        #1;
        chk("full_ready2", st_ready_o, 0);
        chk("full_stable_valid", mem_valid_o, 1);
        chk("full_stable_addr2", mem_addr_o, 64'h3000);
        @(negedge clk);
        mem_ready_i = 1;
        #1;
        chk("full_issue_tid", mem_tid_o, 0);
        chk("full_issue_ready", st_ready_o, 0);
        @(negedge clk);
        mem_ready_i   = 0;
        mem_ack_i     = 1;
        mem_ack_tid_i = 0;
        #1;
        chk("full_inflight_ready", st_ready_o, 0);
        @(negedge clk);
        mem_ack_i = 0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            #1;
            if (st_ready_o) got = 1;
            else @(negedge clk);
        end
        chk("stall_release", got, 1);
        @(negedge clk);
        idle(64'h4000);
        #1;
        chk("ninth_hit", chk_hit_o, 1);
        chk("ninth_ready", st_ready_o, 0);
        @(negedge clk);

        // reset with entries in flight: later ack must be ignored
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 64'h1000 + 64'(i * 8), 64'(i), 8'hFF, 1, 0, 0, 64'h1000);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 1, 0, 0, 64'h1000);
        @(negedge clk);
        #1;
        chk("pre_rst_valid", mem_valid_o, 0);
        chk("pre_rst_empty", empty_o, 0);
        drive(0, 0, 0, 0, 0, 1, 2'd1, 64'h1000);
        rst_i = 1;
        @(negedge clk);
        rst_i = 0;
        drive(0, 0, 0, 0, 0, 1, 2'd1, 64'h1000);
        @(negedge clk);
        idle(64'h1000);
        #1;
        chk("post_rst_empty", empty_o, 1);
        chk("post_rst_hit", chk_hit_o, 0);
        chk("post_rst_ready", st_ready_o, 1);
        chk("post_rst_valid", mem_valid_o, 0);
        drive(1, 64'h1000, 64'h5, 8'h01, 1, 0, 0, 64'h1000);
        @(negedge clk);
        idle(64'h1000);
        #1;
        chk("post_rst_tid", mem_tid_o, 0);
        chk("post_rst_issue", mem_valid_o, 1);
        @(negedge clk);

        // coalescing candidates while all TIDs are busy
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 64'h5000 + 64'(i * 8), 64'(i), 8'hFF, 1, 0, 0, 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        drive(1, 64'h2000, 64'h0000_0000_4433_2211, 8'h0F, 1, 0, 0, 0);
        #1;
        chk("co_first_ready", st_ready_o, 1);
        @(negedge clk);
        drive(1, 64'h2004, 64'h8877_6655_0000_0000, 8'hF0, 1, 0, 0, 0);
        #1;
        chk("co_second_ready", st_ready_o, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 1, 2'd0, 0);
        #1;
        chk("co_no_tid", mem_valid_o, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        chk("co_req1_valid", mem_valid_o, 1);
        chk("co_req1_addr", mem_addr_o, 64'h2000);
        chk("co_req1_tid", mem_tid_o, 0);
`ifdef WT_STORE_WBUF_COALESCE_EN
        chk("co_req1_be", mem_be_o, 8'hFF);
        chk("co_req1_data", mem_data_o, 64'h8877_6655_4433_2211);
`else
        chk("co_req1_be", mem_be_o, 8'h0F);
        chk("co_req1_data", mem_data_o, 64'h0000_0000_4433_2211);
`endif
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 1, 2'd1, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        #1;
`ifdef WT_STORE_WBUF_COALESCE_EN
        chk("co_req2_valid", mem_valid_o, 0);
`else
        chk("co_req2_valid", mem_valid_o, 1);
        chk("co_req2_tid", mem_tid_o, 1);
        chk("co_req2_be", mem_be_o, 8'hF0);
        chk("co_req2_data", mem_data_o, 64'h8877_6655_0000_0000);
`endif
        @(negedge clk);

        // randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) rand_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wt_store_wbuf.md
WT_STORE_WBUF -- requirements
Module: wt_store_wbuf

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of buffer entries (power of two, at least 2).
REQ-002 SHALL have parameter ADDR_W, default 64, store address width.
REQ-003 SHALL have parameter DATA_W, default 64, store data width (power of two, at least 8).
REQ-004 SHALL have parameter TID_W, default 2, memory transaction ID width; at most 2^TID_W entries in flight.
REQ-005 SHALL have ports `clk_i` (in, 1, clock) and `rst_i` (in, 1, reset); one clock, reset synchronous and active-high.
REQ-006 SHALL have store-side ports `st_valid_i` in 1, `st_ready_o` out 1, `st_addr_i` in ADDR_W, `st_data_i` in DATA_W and `st_be_i` in DATA_W/8 byte enables.
REQ-007 SHALL have memory request ports `mem_valid_o` out 1, `mem_ready_i` in 1, `mem_addr_o` out ADDR_W, `mem_data_o` out DATA_W, `mem_be_o` out DATA_W/8 and `mem_tid_o` out TID_W.
REQ-008 SHALL have memory acknowledge ports `mem_ack_i` in 1 and `mem_ack_tid_i` in TID_W.
REQ-009 SHALL have forwarding-check ports `chk_addr_i` in ADDR_W and `chk_hit_o` out 1, plus `empty_o` out 1.

Function
REQ-010 Each entry SHALL be in one of three states: FREE, VALID (buffered, not yet sent) or INFLIGHT (sent, awaiting ack).
REQ-011 Entries SHALL form a ring with pointers wr_ptr (allocate) and iss_ptr (issue), each wrapping from DEPTH-1 to 0.
REQ-012 `st_ready_o` SHALL equal (entry[wr_ptr] is FREE); a handshake SHALL write the entry with the address aligned to DATA_W/8 bytes, set it VALID and advance wr_ptr.
REQ-013 `mem_valid_o` SHALL be 1 when entry[iss_ptr] is VALID and a TID is free, driven combinationally from registered state; a store accepted in cycle N SHALL be presentable at N+1 at the earliest.
REQ-014 `mem_*` outputs SHALL stay stable while `mem_valid_o`=1 and `mem_ready_i`=0.
REQ-015 `mem_tid_o` SHALL be the lowest-numbered free TID; on the handshake the entry SHALL become INFLIGHT, record that TID and advance iss_ptr.
REQ-016 When `mem_ack_i`=1, the INFLIGHT entry holding `mem_ack_tid_i` SHALL become FREE and its TID SHALL be released at the clock edge; an ack for a TID that is not in use SHALL be ignored.
REQ-017 An ack and a new issue in the same cycle SHALL both take effect; the TID being released SHALL NOT be reused until the next cycle.
REQ-018 Entries SHALL be issued strictly in allocation order; acks MAY arrive in any order.
REQ-019 `chk_hit_o` SHALL be combinational: 1 if any non-FREE entry's aligned address equals the aligned `chk_addr_i`.
REQ-020 `empty_o` SHALL be 1 when all entries are FREE.

Reset
REQ-021 While `rst_i`=1 at an edge, all entries SHALL become FREE, both pointers 0 and all TIDs free; outstanding acks SHALL be discarded.
REQ-022 After reset: `st_ready_o`=1, `mem_valid_o`=0, `chk_hit_o`=0 and `empty_o`=1, with `mem_addr_o`, `mem_data_o`, `mem_be_o` and `mem_tid_o` all 0.

Configuration
REQ-023 Macro WT_STORE_WBUF_COALESCE_EN SHALL compile in store coalescing.
REQ-024 With the macro defined, a store whose aligned address matches entry[wr_ptr-1] while that entry is VALID and not being issued this cycle SHALL merge into it (bytes with `st_be_i` set overwrite; byte enables OR together), SHALL NOT allocate a new entry, and `st_ready_o` SHALL be 1 for it even when entry[wr_ptr] is not FREE.
REQ-025 Without the macro, every accepted store SHALL allocate a new entry.

Structure
REQ-026 The entry-state enum (FREE/VALID/INFLIGHT) and the entry record typedef SHALL live in the shared CVA6 package; DEPTH and TID_W defaults SHALL track the write-buffer depth and memory TID width constants there.
REQ-027 One sub-module, wt_wbuf_tid_alloc (a free-TID bitmap with lowest-free priority encoder), SHALL be instantiated.

Verification
REQ-028 Reset, then push addr 0x1000, data 0xAA, be 0x01 with `mem_ready_i`=1 -> mem request in the next cycle with tid 0; ack tid 0 -> `empty_o`=1.
REQ-029 Hold `mem_ready_i`=0 and push 8 stores -> `st_ready_o`=0 after the 8th; a 9th store stalls until an ack frees a slot.
REQ-030 Issue 4 stores with no acks -> `mem_valid_o`=0 with a 5th store VALID; ack tid 2 -> the 5th issues with tid 2.
REQ-031 With the macro defined, push 0x2000/be 0x0F then 0x2004/be 0xF0 while the memory stalls -> one entry with be 0xFF; without the macro -> two entries.
REQ-032 Assert `rst_i` with 3 entries INFLIGHT, then ack tid 1 -> ack ignored, `empty_o`=1 and `chk_hit_o`=0 for 0x1000.
